instruction_memory_loader: RTL and testbench
============================================

Name: instruction_memory_loader

Overview:
Instruction store feeding the processor's fetch stage, sitting directly upstream of it. Returns the 32-bit instruction addressed by the processor's PC. Contains a byte-stream program loader that fills the store from a host (UART/JTAG bridge) and holds the processor in reset while loading.

Parameters:
DEPTH, 256, number of 32-bit instruction words in the store; power of two.
ADDR_W, 8, word-index width; equals log2(DEPTH).

Ports:
clock  input  1  system clock.
reset  input  1  synchronous, active-high reset.
pc  input  32  byte address from the processor's fetch stage.
instruction  output  32  instruction word at pc, combinational read.
load_start  input  1  one-cycle pulse that begins a program load.
load_byte  input  8  host byte stream.
load_valid  input  1  load_byte holds a valid byte.
load_ready  output  1  loader accepts a byte this cycle.
cpu_hold  output  1  OR-ed into the processor reset; high while a load is in progress.
load_done  output  1  one-cycle pulse when a load completes.
load_overflow  output  1  sticky; set when the header count exceeded DEPTH.

Behaviour:
- Read path: instruction = mem[pc[ADDR_W+1:2]] when pc[31:ADDR_W+2]==0, else 32'h0. Combinational, zero latency, because the processor latches it on the same edge that advances PC. pc[1:0] is ignored.
- Memory is not cleared by reset; contents persist across reset and aborted loads.
- FSM states: IDLE, COUNT_HI, COUNT_LO, DATA, DONE.
- IDLE: load_start -> COUNT_HI.
- COUNT_HI: accept a byte -> count[15:8], go to COUNT_LO.
- COUNT_LO: accept a byte -> count[7:0]. If the 16-bit count == 0, go to DONE; else go to DATA.
- DATA: accept bytes in big-endian order, first byte = bits 31:24. On the 4th byte:
  - if word_idx < DEPTH, write the assembled word to mem[word_idx];
  - increment word_idx, clear byte_cnt;
  - when word_idx+1 == count, go to DONE.
- DONE: lasts one cycle, load_done=1, then IDLE.
- A byte is accepted only on load_valid && load_ready. load_ready = 1 in COUNT_HI/COUNT_LO/DATA, 0 otherwise.
- A word written on edge N is visible on instruction in cycle N+1.
- Overflow: if count > DEPTH, set load_overflow in the COUNT_LO->DATA transition. All count*4 bytes are still consumed; words at index >= DEPTH are discarded. load_overflow clears on the next load_start or on reset.
- cpu_hold = (state != IDLE); this includes DONE, so the processor restarts at PC 0 the cycle after load_done.
- load_start outside IDLE is ignored. load_start together with reset: reset wins.
- Reset, including mid-load: state=IDLE, word_idx=0, byte_cnt=0, count=0, load_done=0, load_overflow=0, cpu_hold=0, load_ready=0. A partial word is discarded; words already written remain.
- word_idx is 16 bits wide and does not wrap within one load (count <= 65535).

Decomposition:
- Shared package: loader state enum, NOP constant 32'h0, byte-lane ordering constant.
- Natural sub-module: byte_to_word_assembler (4-byte shift register plus 2-bit counter; outputs word and word_valid).
- Storage is an inline register array; FSM and read mux stay in the top module.

Test Plan:
- Load 2 words: stream 00 02 24 01 00 05 00 21 10 20 -> load_done one cycle after the 10th byte. mem[0]=32'h24010005, mem[1]=32'h00211020. instruction=32'h24010005 at pc=0 and 32'h00211020 at pc=4 and at pc=6.
- Zero count: load_start then 00 00 -> DONE the next cycle. cpu_hold drops after load_done. No write occurs.
- Backpressure and gaps: load_valid toggles randomly during a 3-word load -> load_ready high only in load states, exact words stored, cpu_hold high throughout.
- Overflow with DEPTH=4: count=6, 24 bytes -> load_overflow=1, mem[0..3] hold words 0-3, words 4-5 dropped, load_done pulses once.
- Reset mid-load after 5 data bytes -> all outputs at reset values next cycle. mem[0] keeps the new word; mem[1] keeps its old value.
- Out-of-range read: pc=32'h400 with DEPTH=256 -> instruction=32'h0. load_start during DATA -> ignored, load continues.

Source files
------------

// File: rtl/instruction_memory_loader_pkg.sv
// Shared types and constants for the instruction store and its byte-stream program loader.
package instruction_memory_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT_HI,
    ST_COUNT_LO,
    ST_DATA,
    ST_DONE
  } loader_state_e;

  // Returned for fetches outside the populated store.
  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int BYTES_PER_WORD = 4;
  // Big-endian stream: byte index 3 is the last one and lands in bits 7:0.
  localparam logic [1:0] LAST_BYTE_IDX = 2'd3;

  function automatic logic [31:0] shift_in_byte(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

endpackage

// File: rtl/instruction_memory_loader_assembler.sv
// Packs a big-endian byte stream into 32-bit words; word_valid_o fires combinationally
// with the fourth byte so the word can be written on the same edge that accepts it.
module instruction_memory_loader_assembler
  import instruction_memory_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shifted;

  assign shifted = shift_in_byte({8'h00, shift_q}, byte_i);

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_valid_i) begin
      shift_d = shifted[23:0];
      cnt_d   = cnt_q + 2'd1;
    end
  end

  assign word_o       = shifted;
  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == LAST_BYTE_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_memory_loader.sv
// Instruction store with a zero-latency fetch port and a host-driven program loader
// that holds the processor in reset while a new image is streamed in.
module instruction_memory_loader
  import instruction_memory_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instruction,
  input  logic        load_start,
  input  logic [7:0]  load_byte,
  input  logic        load_valid,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_overflow
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  loader_state_e state_q, state_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic          overflow_q, overflow_d;

  logic          byte_fire;
  logic [31:0]   asm_word;
  logic          asm_word_valid;
  logic          mem_we;

  logic [31:0]   mem [DEPTH];

  assign byte_fire = load_valid && load_ready;

  // Anything other than DATA flushes a partial word, so aborts never leak bytes.
  instruction_memory_loader_assembler u_asm (
    .clock        (clock),
    .reset        (reset),
    .clear_i      (state_q != ST_DATA),
    .byte_valid_i (byte_fire && (state_q == ST_DATA)),
    .byte_i       (load_byte),
    .word_o       (asm_word),
    .word_valid_o (asm_word_valid)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_COUNT_HI;
          count_d    = '0;
          word_idx_d = '0;
          overflow_d = 1'b0;
        end
      end
      ST_COUNT_HI: begin
        if (byte_fire) begin
          count_d = {load_byte, count_q[7:0]};
          state_d = ST_COUNT_LO;
        end
      end
      ST_COUNT_LO: begin
        if (byte_fire) begin
          count_d = {count_q[15:8], load_byte};
          if (count_d == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DATA;
            if ({1'b0, count_d} > DEPTH_L) overflow_d = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (asm_word_valid) begin
          word_idx_d = word_idx_q + 16'd1;
          if (word_idx_d == count_q) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == ST_COUNT_HI) || (state_q == ST_COUNT_LO) || (state_q == ST_DATA);
    cpu_hold   = (state_q != ST_IDLE);
    load_done  = (state_q == ST_DONE);
  end

  assign load_overflow = overflow_q;

  // Words beyond the store are consumed from the stream but dropped here.
  assign mem_we = asm_word_valid && ({1'b0, word_idx_q} < DEPTH_L);

  // No reset: the program image survives processor resets and aborted loads.
  always_ff @(posedge clock) begin
    if (mem_we) mem[word_idx_q[ADDR_W-1:0]] <= asm_word;
  end

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^pc[1:0];

  assign instruction = (pc[31:ADDR_W+2] == '0) ? mem[pc[ADDR_W+1:2]] : NOP;

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Drives two loaders (DEPTH 256 and DEPTH 4) with one shared host stream and
// checks fetched words against a scoreboard of the words that were streamed in.
module tb_instruction_memory_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic [31:0] pc = 32'h0;

  logic [31:0] instr_b, instr_s;
  logic        ready_b, ready_s, hold_b, hold_s, done_b, done_s, ovf_b, ovf_s;

  always #5 clock = ~clock;

  instruction_memory_loader #(.DEPTH(256), .ADDR_W(8)) u_big (
    .clock(clock), .reset(reset), .pc(pc), .instruction(instr_b),
    .load_start(load_start), .load_byte(load_byte), .load_valid(load_valid),
    .load_ready(ready_b), .cpu_hold(hold_b), .load_done(done_b), .load_overflow(ovf_b)
  );

  instruction_memory_loader #(.DEPTH(4), .ADDR_W(2)) u_small (
    .clock(clock), .reset(reset), .pc(pc), .instruction(instr_s),
    .load_start(load_start), .load_byte(load_byte), .load_valid(load_valid),
    .load_ready(ready_s), .cpu_hold(hold_s), .load_done(done_s), .load_overflow(ovf_s)
  );

  int tests = 0;
  int fails = 0;

  typedef struct { int unsigned idx; logic [31:0] word; } sb_t;
  typedef struct { logic [31:0] pc; logic [31:0] exp_b; logic [31:0] exp_s; } rd_vec_t;

  sb_t         sb_q[$];
  logic [31:0] wq[$];
  rd_vec_t     vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 2);
      repeat (n) begin
        load_valid = 1'b0;
        check1("ready_in_gap", ready_b, 1'b1);
        check1("hold_in_gap", hold_b, 1'b1);
        tick();
      end
    end
    load_valid = 1'b1;
    load_byte  = b;
    n = 0;
    while (!ready_b && n < 20) begin
      tick();
      n++;
    end
    if (!ready_b) check1("ready_timeout", ready_b, 1'b1);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic run_load(input int cnt, input bit gaps, input bit poke_start);
    logic [31:0] w;
    pulse_start();
    check1("hold_after_start", hold_b, 1'b1);
    check1("ovf_cleared_on_start", ovf_s, 1'b0);
    send_byte(8'(cnt >> 8), gaps);
    send_byte(8'(cnt), gaps);
    check1("ovf_small", ovf_s, cnt > 4);
    check1("ovf_big", ovf_b, cnt > 256);
    for (int i = 0; i < cnt; i++) begin
      w = wq[i];
      sb_q.push_back('{i, w});
      for (int k = 0; k < 4; k++) begin
        if (i == cnt - 1 && k == 3) check1("done_before_last", done_b, 1'b0);
        if (poke_start && i == 1 && k == 1) load_start = 1'b1;
        send_byte(w[31-8*k -: 8], gaps);
        load_start = 1'b0;
      end
      check1("hold_during_data", hold_b, 1'b1);
    end
    check1("load_done_big", done_b, 1'b1);
    check1("load_done_small", done_s, 1'b1);
    check1("ready_low_in_done", ready_b, 1'b0);
    check1("hold_in_done", hold_b, 1'b1);
    tick();
    check1("done_single_pulse", done_b, 1'b0);
    check1("done_single_pulse_s", done_s, 1'b0);
    check1("hold_released", hold_b, 1'b0);
    check1("ready_low_idle", ready_b, 1'b0);
  endtask

  task automatic drain_sb();
    sb_t e;
    while (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      pc = e.idx * 4;
      #1;
      check("mem_big", instr_b, e.word);
      check("mem_small", instr_s, (e.idx < 4) ? e.word : 32'h0);
    end
    pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old1, n0, n1, n2;

    vt[0] = '{32'h0000_0000, 32'h2401_0005, 32'h2401_0005};
    vt[1] = '{32'h0000_0004, 32'h0021_1020, 32'h0021_1020};
    vt[2] = '{32'h0000_0006, 32'h0021_1020, 32'h0021_1020};
    vt[3] = '{32'h0000_0003, 32'h2401_0005, 32'h2401_0005};
    vt[4] = '{32'h0000_0400, 32'h0000_0000, 32'h0000_0000};
    vt[5] = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};

    repeat (2) tick();
    check1("rst_ready", ready_b, 1'b0);
    check1("rst_hold", hold_b, 1'b0);
    check1("rst_done", done_b, 1'b0);
    check1("rst_ovf", ovf_b, 1'b0);
    reset = 1'b0;
    tick();

    // Two-word load from the reference stream, then fixed fetch vectors.
    wq.delete();
    wq.push_back(32'h2401_0005);
    wq.push_back(32'h0021_1020);
    run_load(2, 1'b0, 1'b0);
    drain_sb();
    for (int i = 0; i < 6; i++) begin
      pc = vt[i].pc;
      #1;
      check("rd_vec_big", instr_b, vt[i].exp_b);
      check("rd_vec_small", instr_s, vt[i].exp_s);
    end
    pc = 32'h0;

    // Zero-word load must not disturb the store.
    wq.delete();
    run_load(0, 1'b0, 1'b0);
    #1;
    check("zero_count_no_write", instr_b, 32'h2401_0005);

    // Three words with random gaps and a stray load_start mid-word.
    wq.delete();
    repeat (3) wq.push_back($urandom());
    run_load(3, 1'b1, 1'b1);
    drain_sb();

    // Six words: small store overflows and keeps only the first four.
    wq.delete();
    repeat (6) wq.push_back($urandom());
    old1 = wq[1];
    run_load(6, 1'b0, 1'b0);
    check1("ovf_sticky_small", ovf_s, 1'b1);
    check1("ovf_sticky_big", ovf_b, 1'b0);
    drain_sb();

    // Reset partway through the second word of an overflowing load.
    n0 = $urandom();
    n1 = $urandom();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h06, 1'b0);
    check1("ovf_before_reset", ovf_s, 1'b1);
    for (int k = 0; k < 4; k++) send_byte(n0[31-8*k -: 8], 1'b0);
    send_byte(n1[31:24], 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check1("midrst_ready", ready_b, 1'b0);
    check1("midrst_hold", hold_b, 1'b0);
    check1("midrst_done", done_b, 1'b0);
    check1("midrst_ovf_small", ovf_s, 1'b0);
    pc = 32'h0;
    #1;
    check("midrst_word0_kept", instr_b, n0);
    check("midrst_word0_kept_s", instr_s, n0);
    pc = 32'h4;
    #1;
    check("midrst_word1_old", instr_b, old1);
    check("midrst_word1_old_s", instr_s, old1);
    pc = 32'h0;

    // Partial word from the aborted load must not prefix the next one.
    n2 = $urandom();
    wq.delete();
    wq.push_back(n2);
    run_load(1, 1'b0, 1'b0);
    drain_sb();

    // load_start together with reset: reset wins.
    load_start = 1'b1;
    reset = 1'b1;
    tick();
    load_start = 1'b0;
    reset = 1'b0;
    check1("start_with_reset_hold", hold_b, 1'b0);
    check1("start_with_reset_ready", ready_b, 1'b0);
    tick();
    check1("start_with_reset_idle", hold_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
